rx_port_scheduler: RTL and testbench

RX_PORT_SCHEDULER -- requirements
Module: rx_port_scheduler

---
 rtl/rx_port_scheduler.sv | 161 ++++++++++++++++
 tb/tb_rx_port_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_port_scheduler.sv
// rx_port_scheduler: round-robin drain of NUM_PORTS packet FIFOs onto one 32-bit AXI-Stream.
// Optional macro RX_SCHED_PKT_COUNT_EN adds per-port 16-bit packet counters on pkt_count.

module rx_sched_port #(
  parameter int PW  = 2,
  parameter int IDX = 0
) (
`ifdef RX_SCHED_PKT_COUNT_EN
  input  logic          aclk,
  input  logic          aresetn,
  output logic [15:0]   pkt_cnt,
`endif
  input  logic          flush_en,
  input  logic [PW-1:0] grant,
  output logic          flush
);
  assign flush = flush_en && (grant == PW'(IDX));

`ifdef RX_SCHED_PKT_COUNT_EN
  // Counts every flushed packet, zero-length ones included; wraps naturally.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)   pkt_cnt <= '0;
    else if (flush) pkt_cnt <= pkt_cnt + 16'd1;
  end
`endif
endmodule

module rx_port_scheduler #(
  parameter int NUM_PORTS      = 4,
  parameter int FIFO_ADDR_SIZE = 10,
  localparam int PW            = $clog2(NUM_PORTS)
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [NUM_PORTS-1:0]                fifo_ready,
  input  logic [NUM_PORTS*FIFO_ADDR_SIZE-1:0] fifo_data_len,
  input  logic [NUM_PORTS*32-1:0]             fifo_data,
  output logic [FIFO_ADDR_SIZE-1:0]           fifo_read_ptr,
  output logic [NUM_PORTS-1:0]                fifo_flush,
  output logic [31:0]                         m_axis_tdata,
  output logic [3:0]                          m_axis_tkeep,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  output logic [PW-1:0]                       m_axis_tdest,
  output logic                                busy
`ifdef RX_SCHED_PKT_COUNT_EN
  ,
  output logic [NUM_PORTS*16-1:0]             pkt_count
`endif
);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  localparam logic [FIFO_ADDR_SIZE:0] FOUR = 4;

  state_t                                  state, state_nxt;
  logic [PW-1:0]                           grant, grant_nxt;
  logic [PW-1:0]                           last_grant, last_grant_nxt;
  logic [PW-1:0]                           win;
  logic                                    win_vld;
  logic [FIFO_ADDR_SIZE-1:0]               rd_ptr, rd_ptr_nxt;
  logic [FIFO_ADDR_SIZE:0]                 remaining;
  logic [NUM_PORTS-1:0][FIFO_ADDR_SIZE-1:0] len_a;
  logic [NUM_PORTS-1:0][31:0]              data_a;

  assign len_a  = fifo_data_len;
  assign data_a = fifo_data;

  // Round-robin: first ready port strictly after the previous winner.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!win_vld && fifo_ready[(int'(last_grant) + k) % NUM_PORTS]) begin
        win_vld = 1'b1;
        win     = PW'((int'(last_grant) + k) % NUM_PORTS);
      end
    end
  end

  // One extra bit so a pointer past the length cannot alias to a small count.
  assign remaining = {1'b0, len_a[grant]} - {1'b0, rd_ptr};

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    rd_ptr_nxt     = rd_ptr;
    case (state)
      IDLE: begin
        rd_ptr_nxt = '0;
        if (win_vld) begin
          grant_nxt      = win;
          last_grant_nxt = win;
          state_nxt      = (len_a[win] == '0) ? FLUSH : STREAM;
        end
      end
      STREAM: begin
        if (m_axis_tready) begin
          if (m_axis_tlast) state_nxt  = FLUSH;
          else              rd_ptr_nxt = rd_ptr + FIFO_ADDR_SIZE'(4);
        end
      end
      FLUSH: begin
        rd_ptr_nxt = '0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= PW'(NUM_PORTS - 1);
      rd_ptr     <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      rd_ptr     <= rd_ptr_nxt;
    end
  end

  // Beat outputs are gated by state so reset clears them without a clock.
  assign m_axis_tvalid = (state == STREAM);
  assign m_axis_tdata  = m_axis_tvalid ? data_a[grant] : '0;
  assign m_axis_tlast  = m_axis_tvalid && (remaining <= FOUR);
  assign m_axis_tdest  = grant;
  assign fifo_read_ptr = rd_ptr;
  assign busy          = (state != IDLE);

  always_comb begin
    m_axis_tkeep = 4'b0000;
    if (m_axis_tvalid) begin
      if (remaining >= FOUR) m_axis_tkeep = 4'b1111;
      else begin
        case (remaining[1:0])
          2'd1:    m_axis_tkeep = 4'b0001;
          2'd2:    m_axis_tkeep = 4'b0011;
          2'd3:    m_axis_tkeep = 4'b0111;
          default: m_axis_tkeep = 4'b0000;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    rx_sched_port #(.PW(PW), .IDX(i)) u_port (
`ifdef RX_SCHED_PKT_COUNT_EN
      .aclk     (aclk),
      .aresetn  (aresetn),
      .pkt_cnt  (pkt_count[i*16 +: 16]),
`endif
      .flush_en (state == FLUSH),
      .grant    (grant),
      .flush    (fifo_flush[i])
    );
  end
endmodule

// File: tb/tb_rx_port_scheduler.sv
// tb_rx_port_scheduler: queue-based FIFO/scoreboard model driving rx_port_scheduler with random traffic.
// Build with RX_SCHED_PKT_COUNT_EN defined to also check the packet counters.

module tb_rx_port_scheduler;
  localparam int NP = 4;
  localparam int AW = 10;
  localparam int PW = 2;

  logic               aclk = 1'b0;
  logic               aresetn = 1'b0;
  logic [NP-1:0]      fifo_ready;
  logic [NP*AW-1:0]   fifo_data_len;
  logic [NP*32-1:0]   fifo_data;
  logic [AW-1:0]      fifo_read_ptr;
  logic [NP-1:0]      fifo_flush;
  logic [31:0]        m_axis_tdata;
  logic [3:0]         m_axis_tkeep;
  logic               m_axis_tvalid;
  logic               m_axis_tlast;
  logic               m_axis_tready;
  logic [PW-1:0]      m_axis_tdest;
  logic               busy;
`ifdef RX_SCHED_PKT_COUNT_EN
  logic [NP*16-1:0]   pkt_count;
`endif

  rx_port_scheduler #(.NUM_PORTS(NP), .FIFO_ADDR_SIZE(AW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .fifo_ready    (fifo_ready),
    .fifo_data_len (fifo_data_len),
    .fifo_data     (fifo_data),
    .fifo_read_ptr (fifo_read_ptr),
    .fifo_flush    (fifo_flush),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdest  (m_axis_tdest),
    .busy          (busy)
`ifdef RX_SCHED_PKT_COUNT_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO model: queued packet lengths per port, per-packet data seed.
  int                 lenq [NP][$];
  logic [NP-1:0][31:0] seed;
  int                 cnt_m [NP];
  int                 exp_last, mphase, mport, beat;
  bit                 logged;
  int                 tr_mode;
  int                 trq [$];
  int                 glog [$];
  int                 blog [$];

  always_comb begin
    for (int p = 0; p < NP; p++)
      fifo_data[p*32 +: 32] = {fifo_read_ptr[7:0] + 8'd3, fifo_read_ptr[7:0] + 8'd2,
                               fifo_read_ptr[7:0] + 8'd1, fifo_read_ptr[7:0]} ^ seed[p];
  end

  function automatic logic [31:0] exp_word(input int p, input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b} ^ seed[p];
  endfunction

  function automatic int rr_pick(input int last, input logic [NP-1:0] rdy);
    for (int k = 1; k <= NP; k++)
      if (rdy[(last + k) % NP]) return (last + k) % NP;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int p = 0; p < NP; p++) if (lenq[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic apply_inputs();
    for (int p = 0; p < NP; p++) begin
      fifo_ready[p] = (lenq[p].size() != 0);
      fifo_data_len[p*AW +: AW] = (lenq[p].size() != 0) ? AW'(lenq[p][0]) : '0;
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      lenq[p].delete();
      cnt_m[p] = 0;
    end
    trq.delete();
    exp_last = NP - 1;
    mphase   = 0;
    beat     = 0;
    logged   = 1'b0;
  endtask

  // Inputs land before the next rising edge; an idle scheduler grants on that edge.
  task automatic drive_and_predict(input bit no_pred);
    int g;
    apply_inputs();
    if (!no_pred && aresetn && mphase == 0 && |fifo_ready) begin
      g        = rr_pick(exp_last, fifo_ready);
      exp_last = g;
      mport    = g;
      beat     = 0;
      logged   = 1'b0;
      mphase   = (lenq[g][0] == 0) ? 2 : 1;
    end
  endtask

  task automatic step();
    int         rem;
    logic [3:0] ek;
    bit         no_pred;
    @(negedge aclk);
    no_pred = 1'b0;
    if (trq.size() > 0 && mphase == 1) m_axis_tready = (trq.pop_front() != 0);
    else m_axis_tready = (tr_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
`ifdef RX_SCHED_PKT_COUNT_EN
    for (int p = 0; p < NP; p++)
      chk("pkt_count", 32'(pkt_count[p*16 +: 16]), 32'(cnt_m[p] & 32'hffff));
`endif
    case (mphase)
      0: begin
        chk("idle_busy",   32'(busy), 0);
        chk("idle_tvalid", 32'(m_axis_tvalid), 0);
        chk("idle_flush",  32'(fifo_flush), 0);
        chk("idle_ptr",    32'(fifo_read_ptr), 0);
      end
      1: begin
        rem = lenq[mport][0] - 4 * beat;
        ek  = (rem >= 4) ? 4'hf : 4'((1 << rem) - 1);
        if (!logged) begin
          glog.push_back(int'(m_axis_tdest));
          logged = 1'b1;
        end
        chk("str_busy",   32'(busy), 1);
        chk("str_tvalid", 32'(m_axis_tvalid), 1);
        chk("str_tdest",  32'(m_axis_tdest), 32'(mport));
        chk("str_ptr",    32'(fifo_read_ptr), 32'(4 * beat));
        chk("str_tkeep",  32'(m_axis_tkeep), 32'(ek));
        chk("str_tlast",  32'(m_axis_tlast), 32'(rem <= 4));
        chk("str_tdata",  m_axis_tdata, exp_word(mport, 4 * beat));
        chk("str_flush",  32'(fifo_flush), 0);
        if (m_axis_tready) begin
          if (rem <= 4) mphase = 2;
          else          beat++;
        end
      end
      default: begin
        if (!logged) begin
          glog.push_back(int'(m_axis_tdest));
          logged = 1'b1;
        end
        chk("fl_flush",  32'(fifo_flush), 32'(1 << mport));
        chk("fl_tvalid", 32'(m_axis_tvalid), 0);
        chk("fl_busy",   32'(busy), 1);
        blog.push_back((lenq[mport][0] == 0) ? 0 : beat + 1);
        void'(lenq[mport].pop_front());
        cnt_m[mport]++;
        seed[mport] = $urandom;
        mphase  = 0;
        no_pred = 1'b1;
      end
    endcase
    drive_and_predict(no_pred);
  endtask

  task automatic run_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (mphase == 0 && all_empty()) return;
    end
    chk("drain_timeout", 1, 0);
  endtask

  task automatic finish_reset();
    model_reset();
    apply_inputs();
    step();
    step();
  endtask

  task automatic release_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    drive_and_predict(1'b0);
  endtask

  initial begin
    m_axis_tready = 1'b1;
    tr_mode = 0;
    for (int p = 0; p < NP; p++) seed[p] = $urandom;
    model_reset();
    apply_inputs();

    // Reset state, sampled between edges.
    #3;
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_tlast",  32'(m_axis_tlast), 0);
    chk("rst_tkeep",  32'(m_axis_tkeep), 0);
    chk("rst_tdata",  m_axis_tdata, 0);
    chk("rst_tdest",  32'(m_axis_tdest), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_flush",  32'(fifo_flush), 0);
    chk("rst_ptr",    32'(fifo_read_ptr), 0);

    // All ports ready from reset: 0,1,2,3,0.
    lenq[0].push_back(5); lenq[0].push_back(9);
    lenq[1].push_back(8);
    lenq[2].push_back(3);
    lenq[3].push_back(7);
    apply_inputs();
    release_reset();
    run_idle(200);
    chk("rr_count", 32'(glog.size()), 5);
    if (glog.size() == 5) begin
      chk("rr_g0", 32'(glog[0]), 0);
      chk("rr_g1", 32'(glog[1]), 1);
      chk("rr_g2", 32'(glog[2]), 2);
      chk("rr_g3", 32'(glog[3]), 3);
      chk("rr_g4", 32'(glog[4]), 0);
    end

    // Port 1, 10 bytes: three beats ending in a two-byte keep.
    glog.delete(); blog.delete();
    lenq[1].push_back(10);
    run_idle(100);
    chk("len10_port", 32'(glog.size() > 0 ? glog[0] : -1), 1);
    chk("len10_beats", 32'(blog.size() > 0 ? blog[0] : -1), 3);

    // tready 1,0,0,1 over an 8-byte packet.
    glog.delete(); blog.delete();
    trq = '{1, 0, 0, 1};
    lenq[0].push_back(8);
    run_idle(100);
    chk("bp_beats", 32'(blog.size() > 0 ? blog[0] : -1), 2);

    // Zero-length packet goes straight to flush.
    glog.delete(); blog.delete();
    lenq[2].push_back(0);
    run_idle(100);
    chk("zero_port", 32'(glog.size() > 0 ? glog[0] : -1), 2);
    chk("zero_beats", 32'(blog.size() > 0 ? blog[0] : -1), 0);

    // Random traffic with random backpressure.
    tr_mode = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        int p;
        p = $urandom_range(0, NP - 1);
        if (lenq[p].size() < 3)
          lenq[p].push_back(($urandom_range(0, 4) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 40));
      end
      step();
    end
    run_idle(3000);
    tr_mode = 0;

    // Reset asserted during beat 2 of a 12-byte packet.
    lenq[1].push_back(4);
    run_idle(100);
    lenq[2].push_back(12);
    begin
      int n;
      n = 0;
      while (!(mphase == 1 && beat == 1) && n < 50) begin
        step();
        n++;
      end
      if (n >= 50) chk("rst_wait_timeout", 1, 0);
    end
    @(posedge aclk);
    #2;
    chk("pre_rst_ptr", 32'(fifo_read_ptr), 4);
    aresetn = 1'b0;
    #1;
    chk("arst_tvalid", 32'(m_axis_tvalid), 0);
    chk("arst_tlast",  32'(m_axis_tlast), 0);
    chk("arst_tkeep",  32'(m_axis_tkeep), 0);
    chk("arst_tdata",  m_axis_tdata, 0);
    chk("arst_tdest",  32'(m_axis_tdest), 0);
    chk("arst_busy",   32'(busy), 0);
    chk("arst_flush",  32'(fifo_flush), 0);
    chk("arst_ptr",    32'(fifo_read_ptr), 0);
    finish_reset();
    glog.delete();
    lenq[0].push_back(6);
    lenq[3].push_back(6);
    release_reset();
    run_idle(100);
    chk("post_rst_first", 32'(glog.size() > 0 ? glog[0] : -1), 0);
    chk("post_rst_second", 32'(glog.size() > 1 ? glog[1] : -1), 3);

`ifdef RX_SCHED_PKT_COUNT_EN
    @(negedge aclk);
    aresetn = 1'b0;
    finish_reset();
    release_reset();
    lenq[3].push_back(5); lenq[3].push_back(1); lenq[3].push_back(0);
    run_idle(200);
    @(negedge aclk);
    chk("cnt_p0", 32'(pkt_count[15:0]), 0);
    chk("cnt_p1", 32'(pkt_count[31:16]), 0);
    chk("cnt_p2", 32'(pkt_count[47:32]), 0);
    chk("cnt_p3", 32'(pkt_count[63:48]), 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
